// File: rtl/osc_acq_seq.sv
// Scope acquisition sequencer: arm, pre-trigger fill, trigger qualification, post-trigger delay.
// Define ACQ_IRQ_EN to enable the acquisition-done interrupt; otherwise irq_o is tied low.
module osc_acq_seq #(
  parameter int AW    = 14,
  parameter int DEB_W = 20,
  parameter int DECW  = 17
) (
  input  logic             clk0,
  input  logic             rstn,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [2:0]       trig_src_i,
  input  logic             sw_trig_i,
  input  logic             adc_cmp_i,
  input  logic             ext_trig_i,
  input  logic             asg_trig_i,
  input  logic [DEB_W-1:0] deb_len_i,
  input  logic [DECW-1:0]  dec_i,
  input  logic [AW-1:0]    pretrig_i,
  input  logic [31:0]      dly_i,
  input  logic             irq_ack_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_ptr_o,
  output logic [AW-1:0]    trig_ptr_o,
  output logic             trig_o,
  output logic             src_clr_o,
  output logic [2:0]       state_o,
  output logic             irq_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_reg;
  logic [DECW-1:0]  dec_cnt_reg;
  logic [AW-1:0]    pre_cnt_reg;
  logic [31:0]      post_cnt_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    trig_ptr_reg;
  logic             trig_reg;
  logic             src_clr_reg;

  logic             adc_q_reg, adc_q2_reg;
  logic             ext_s1_reg, ext_s2_reg;
  logic             deb_level_reg, deb_prev_reg;
  logic [DEB_W-1:0] deb_cnt_reg;

  logic [DECW-1:0]  dec_last;
  logic             strobe;
  logic             active;
  logic             wr_en;
  logic             trig_ev;

  // A decimation factor of 0 behaves like 1, so the last count is 0 in both cases.
  assign dec_last = (dec_i == '0) ? '0 : dec_i - DECW'(1);
  assign strobe   = (dec_cnt_reg >= dec_last);
  assign active   = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
  assign wr_en    = rstn && active && strobe && !abort_i && !arm_i;

  always_comb begin
    trig_ev = 1'b0;
    case (trig_src_i)
      3'd1:    trig_ev = sw_trig_i;
      3'd2:    trig_ev = adc_q_reg && !adc_q2_reg;
      3'd3:    trig_ev = !adc_q_reg && adc_q2_reg;
      3'd4:    trig_ev = deb_level_reg && !deb_prev_reg;
      3'd5:    trig_ev = !deb_level_reg && deb_prev_reg;
      3'd6:    trig_ev = asg_trig_i;
      default: trig_ev = 1'b0;
    endcase
  end

  // Trigger front end: ADC edge register, EXT synchroniser and debounce.
  always_ff @(posedge clk0) begin
    if (!rstn) begin
      adc_q_reg     <= 1'b0;
      adc_q2_reg    <= 1'b0;
      ext_s1_reg    <= 1'b0;
      ext_s2_reg    <= 1'b0;
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
      deb_cnt_reg   <= '0;
    end else begin
      adc_q_reg    <= adc_cmp_i;
      adc_q2_reg   <= adc_q_reg;
      ext_s1_reg   <= ext_trig_i;
      ext_s2_reg   <= ext_s1_reg;
      deb_prev_reg <= deb_level_reg;
      if (deb_len_i == '0) begin
        deb_level_reg <= ext_s2_reg;
        deb_cnt_reg   <= '0;
      end else if (ext_s2_reg == deb_level_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg + DEB_W'(1) >= deb_len_i) begin
        deb_level_reg <= ext_s2_reg;
        deb_cnt_reg   <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstn) begin
      state_reg    <= S_IDLE;
      dec_cnt_reg  <= '0;
      pre_cnt_reg  <= '0;
      post_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      trig_ptr_reg <= '0;
      trig_reg     <= 1'b0;
      src_clr_reg  <= 1'b0;
    end else begin
      trig_reg    <= 1'b0;
      src_clr_reg <= 1'b0;
      if (abort_i) begin
        state_reg   <= S_IDLE;
        dec_cnt_reg <= strobe ? '0 : dec_cnt_reg + DECW'(1);
      end else if (arm_i) begin
        state_reg   <= (pretrig_i == '0) ? S_WAIT : S_PRE;
        wr_ptr_reg  <= '0;
        dec_cnt_reg <= '0;
        pre_cnt_reg <= '0;
      end else begin
        dec_cnt_reg <= strobe ? '0 : dec_cnt_reg + DECW'(1);
        if (wr_en)
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        case (state_reg)
          S_PRE: begin
            if (strobe) begin
              pre_cnt_reg <= pre_cnt_reg + AW'(1);
              if (pre_cnt_reg + AW'(1) == pretrig_i)
                state_reg <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Pointer captured before this cycle's increment.
            if (trig_ev) begin
              trig_reg     <= 1'b1;
              src_clr_reg  <= 1'b1;
              trig_ptr_reg <= wr_ptr_reg;
              post_cnt_reg <= '0;
              state_reg    <= (dly_i == 32'd0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (strobe) begin
              post_cnt_reg <= post_cnt_reg + 32'd1;
              if (post_cnt_reg + 32'd1 == dly_i)
                state_reg <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ACQ_IRQ_EN
  logic [2:0] state_prev_reg;
  logic       irq_reg;
  logic       done_entry;

  assign done_entry = (state_reg == S_DONE) && (state_prev_reg != S_DONE);

  // A fresh DONE entry wins over a simultaneous acknowledge.
  always_ff @(posedge clk0) begin
    if (!rstn) begin
      state_prev_reg <= S_IDLE;
      irq_reg        <= 1'b0;
    end else begin
      state_prev_reg <= state_reg;
      if (done_entry)
        irq_reg <= 1'b1;
      else if (irq_ack_i)
        irq_reg <= 1'b0;
    end
  end

  assign irq_o = irq_reg;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack_i;
  assign irq_o          = 1'b0;
`endif

  assign wr_en_o    = wr_en;
  assign wr_ptr_o   = wr_ptr_reg;
  assign trig_ptr_o = trig_ptr_reg;
  assign trig_o     = trig_reg;
  assign src_clr_o  = src_clr_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_osc_acq_seq.sv
// Directed bench for osc_acq_seq (AW=4 so pointer wrap is exercised quickly).
module tb_osc_acq_seq;

  localparam int AW    = 4;
  localparam int DEB_W = 20;
  localparam int DECW  = 17;

`ifdef ACQ_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic             clk0 = 1'b0;
  logic             rstn;
  logic             arm_i, abort_i;
  logic [2:0]       trig_src_i;
  logic             sw_trig_i, adc_cmp_i, ext_trig_i, asg_trig_i;
  logic [DEB_W-1:0] deb_len_i;
  logic [DECW-1:0]  dec_i;
  logic [AW-1:0]    pretrig_i;
  logic [31:0]      dly_i;
  logic             irq_ack_i;
  logic             wr_en_o;
  logic [AW-1:0]    wr_ptr_o, trig_ptr_o;
  logic             trig_o, src_clr_o;
  logic [2:0]       state_o;
  logic             irq_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_cnt   = 0;
  int trig_cnt = 0;
  int clr_cnt  = 0;
  int n0, n1, t0, c0;

  osc_acq_seq #(.AW(AW), .DEB_W(DEB_W), .DECW(DECW)) dut (
    .clk0       (clk0),
    .rstn       (rstn),
    .arm_i      (arm_i),
    .abort_i    (abort_i),
    .trig_src_i (trig_src_i),
    .sw_trig_i  (sw_trig_i),
    .adc_cmp_i  (adc_cmp_i),
    .ext_trig_i (ext_trig_i),
    .asg_trig_i (asg_trig_i),
    .deb_len_i  (deb_len_i),
    .dec_i      (dec_i),
    .pretrig_i  (pretrig_i),
    .dly_i      (dly_i),
    .irq_ack_i  (irq_ack_i),
    .wr_en_o    (wr_en_o),
    .wr_ptr_o   (wr_ptr_o),
    .trig_ptr_o (trig_ptr_o),
    .trig_o     (trig_o),
    .src_clr_o  (src_clr_o),
    .state_o    (state_o),
    .irq_o      (irq_o)
  );

  always #5 clk0 = ~clk0;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk0) begin
    if (wr_en_o)   wr_cnt++;
    if (trig_o)    trig_cnt++;
    if (src_clr_o) clr_cnt++;
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_o != s && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state_o), 32'(s));
  endtask

  task automatic wait_ptr(input logic [AW-1:0] p, input int budget, input string tag);
    int n = 0;
    while (wr_ptr_o != p && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(wr_ptr_o), 32'(p));
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_src_i = 3'd0;
    sw_trig_i = 1'b0; adc_cmp_i = 1'b0; ext_trig_i = 1'b0; asg_trig_i = 1'b0;
    deb_len_i = '0; dec_i = 17'd1; pretrig_i = '0; dly_i = 32'd0; irq_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_state",    32'(state_o),    0);
    check("rst_wr_en",    32'(wr_en_o),    0);
    check("rst_wr_ptr",   32'(wr_ptr_o),   0);
    check("rst_trig_ptr", 32'(trig_ptr_o), 0);
    check("rst_trig",     32'(trig_o),     0);
    check("rst_src_clr",  32'(src_clr_o),  0);
    check("rst_irq",      32'(irq_o),      0);
    rstn = 1'b1;
    tick();

    // 1: SW trigger, dec 1, pre 4, post 8; pointer ends at 19 mod 16
    dec_i = 17'd1; pretrig_i = 4'd4; dly_i = 32'd8; trig_src_i = 3'd1;
    pulse_arm();
    n0 = wr_cnt;
    check("t1_pre", 32'(state_o), 1);
    wait_state(3'd2, 20, "t1_wait");
    check("t1_pre_writes", 32'(wr_cnt - n0), 4);
    check("t1_ptr_at_wait", 32'(wr_ptr_o), 4);
    wait_ptr(4'd10, 20, "t1_ptr10");
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    n1 = wr_cnt;
    check("t1_trig",     32'(trig_o),     1);
    check("t1_src_clr",  32'(src_clr_o),  1);
    check("t1_trig_ptr", 32'(trig_ptr_o), 10);
    check("t1_post",     32'(state_o),    3);
    tick();
    check("t1_trig_pulse", 32'(trig_o), 0);
    wait_state(3'd4, 30, "t1_done");
    check("t1_post_writes", 32'(wr_cnt - n1), 8);
    check("t1_final_ptr",   32'(wr_ptr_o), 3);
    check("t1_irq_entry",   32'(irq_o), 0);
    tick();
    check("t1_irq_set", 32'(irq_o), 32'(IRQ_EXP));
    n1 = wr_cnt;
    repeat (3) tick();
    check("t1_irq_hold",   32'(irq_o), 32'(IRQ_EXP));
    check("t1_done_hold",  32'(state_o), 4);
    check("t1_done_nowr",  32'(wr_cnt - n1), 0);
    pulse_ack();
    check("t1_irq_ack", 32'(irq_o), 0);

    // 2: trigger during PRE ignored, accepted in WAIT
    dec_i = 17'd4; pretrig_i = 4'd2; dly_i = 32'd8; trig_src_i = 3'd1;
    pulse_arm();
    c0 = clr_cnt;
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    check("t2_pre_trig_ignored", 32'(trig_o), 0);
    check("t2_pre_clr_ignored",  32'(src_clr_o), 0);
    check("t2_still_pre",        32'(state_o), 1);
    wait_state(3'd2, 20, "t2_wait");
    check("t2_ptr_at_wait", 32'(wr_ptr_o), 2);
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    check("t2_trig",     32'(trig_o), 1);
    check("t2_post",     32'(state_o), 3);
    check("t2_trig_ptr", 32'(trig_ptr_o), 2);
    tick();
    check("t2_clr_once", 32'(clr_cnt - c0), 1);
    pulse_abort();
    check("t2_abort", 32'(state_o), 0);

    // 3: EXT rising with debounce 5: glitch rejected, trigger 8 cycles after pin rise
    trig_src_i = 3'd4; deb_len_i = 20'd5; dec_i = 17'd1; pretrig_i = 4'd0; dly_i = 32'd8;
    pulse_arm();
    check("t3_direct_wait", 32'(state_o), 2);
    t0 = trig_cnt;
    ext_trig_i = 1'b1; repeat (3) tick(); ext_trig_i = 1'b0;
    repeat (12) tick();
    check("t3_glitch_none", 32'(trig_cnt - t0), 0);
    check("t3_glitch_wait", 32'(state_o), 2);
    ext_trig_i = 1'b1;
    repeat (7) tick();
    check("t3_not_yet", 32'(trig_o), 0);
    tick();
    check("t3_trig_at_8", 32'(trig_o), 1);
    check("t3_post",      32'(state_o), 3);
    repeat (2) tick();
    ext_trig_i = 1'b0;
    pulse_abort();
    repeat (12) tick();

    // 4: pointer wrap, pre 15, trigger in third WAIT cycle, post 20
    trig_src_i = 3'd1; dec_i = 17'd1; pretrig_i = 4'd15; dly_i = 32'd20;
    pulse_arm();
    n0 = wr_cnt;
    wait_state(3'd2, 40, "t4_wait");
    check("t4_ptr_at_wait", 32'(wr_ptr_o), 15);
    tick(); tick();
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    check("t4_trig_ptr", 32'(trig_ptr_o), 1);
    wait_state(3'd4, 40, "t4_done");
    check("t4_final_ptr",   32'(wr_ptr_o), 6);
    check("t4_total_writes", 32'(wr_cnt - n0), 38);
    tick();
    pulse_ack();
    check("t4_irq_ack", 32'(irq_o), 0);

    // 5: ASG trigger, abort in POST, rearm
    trig_src_i = 3'd6; dec_i = 17'd1; pretrig_i = 4'd2; dly_i = 32'd20;
    pulse_arm();
    wait_state(3'd2, 10, "t5_wait");
    asg_trig_i = 1'b1; tick(); asg_trig_i = 1'b0;
    check("t5_trig", 32'(trig_o), 1);
    check("t5_post", 32'(state_o), 3);
    repeat (3) tick();
    check("t5_ptr_before_abort", 32'(wr_ptr_o), 6);
    n1 = wr_cnt;
    pulse_abort();
    check("t5_idle", 32'(state_o), 0);
    repeat (5) tick();
    check("t5_no_writes",   32'(wr_cnt - n1), 0);
    check("t5_ptr_hold",    32'(wr_ptr_o), 6);
    check("t5_trig_ptr_hold", 32'(trig_ptr_o), 2);
    check("t5_irq_low",     32'(irq_o), 0);
    pulse_arm();
    check("t5_rearm_ptr",   32'(wr_ptr_o), 0);
    check("t5_rearm_state", 32'(state_o), 1);

    // 6: dec 0 acts as 1, dly 0 goes straight to DONE; falling edge ignored for src 2
    trig_src_i = 3'd2; dec_i = 17'd0; pretrig_i = 4'd0; dly_i = 32'd0;
    pulse_arm();
    check("t6_wait", 32'(state_o), 2);
    t0 = trig_cnt;
    adc_cmp_i = 1'b1; tick(); tick();
    check("t6_trig",     32'(trig_o), 1);
    check("t6_done",     32'(state_o), 4);
    check("t6_trig_ptr", 32'(trig_ptr_o), 1);
    check("t6_ptr",      32'(wr_ptr_o), 2);
    n1 = wr_cnt;
    repeat (3) tick();
    check("t6_no_post_writes", 32'(wr_cnt - n1), 0);
    check("t6_done_hold",      32'(state_o), 4);
    tick();
    pulse_ack();
    pulse_arm();
    check("t6_rearm_wait", 32'(state_o), 2);
    adc_cmp_i = 1'b0;
    repeat (4) tick();
    check("t6_fall_ignored", 32'(trig_cnt - t0), 1);
    check("t6_fall_state",   32'(state_o), 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
